// File: rtl/exp_sp_arbiter.sv
// exp_sp_arbiter: round-robin front-end sharing one pipelined softplus/exp
// core between an SP requester and an EXP requester. In-flight ops are
// tracked in a tag pipeline aligned with the core latency, and each result
// is returned with its ID on the owning requester's response port.
// Optional protocol checker: define EXP_SP_ARB_CHK_EN to enable the sticky
// err flag; otherwise err is tied low.
module exp_sp_arbiter #(
  parameter int DW       = 16,
  parameter int IDW      = 4,
  parameter int LAT_CORE = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           sp_req_v,
  output logic           sp_req_rdy,
  input  logic [DW-1:0]  sp_x,
  input  logic [IDW-1:0] sp_id,
  input  logic           exp_req_v,
  output logic           exp_req_rdy,
  input  logic [DW-1:0]  exp_x,
  input  logic [IDW-1:0] exp_id,
  output logic           core_v,
  output logic           core_mode,
  output logic [DW-1:0]  core_x,
  input  logic [DW-1:0]  core_y_s,
  input  logic           core_v_s,
  input  logic [DW-1:0]  core_y_e,
  input  logic           core_v_e,
  output logic           sp_rsp_v,
  output logic [DW-1:0]  sp_y,
  output logic [IDW-1:0] sp_rsp_id,
  output logic           exp_rsp_v,
  output logic [DW-1:0]  exp_y,
  output logic [IDW-1:0] exp_rsp_id,
  output logic           idle,
  output logic           err
);

  typedef enum logic {FAV_SP = 1'b0, FAV_EXP = 1'b1} side_t;

  typedef struct packed {
    logic           v;
    logic           mode;
    logic [IDW-1:0] id;
  } tag_t;

  side_t          rr_ptr;
  logic           grant_sp;
  logic           grant_exp;
  logic           grant;
  logic [IDW-1:0] issue_id;
  tag_t           tag_q [LAT_CORE];
  tag_t           head;
  logic           any_tag_v;

  // Grant selection: a lone requester wins, a tie goes to the favoured side.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_sp  = 1'b0;
    grant_exp = 1'b0;
    if (en) begin
      if (sp_req_v && exp_req_v) begin
        grant_sp  = (rr_ptr == FAV_SP);
        grant_exp = (rr_ptr == FAV_EXP);
      end else begin
        grant_sp  = sp_req_v;
        grant_exp = exp_req_v;
      end
    end
  end

  assign grant       = grant_sp | grant_exp;
  assign sp_req_rdy  = grant_sp;
  assign exp_req_rdy = grant_exp;

  // Fairness pointer moves only when a contested cycle is resolved.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= FAV_SP;
    end else if (sp_req_v && exp_req_v && grant) begin
      rr_ptr <= grant_sp ? FAV_EXP : FAV_SP;
    end
  end

  // Issue stage: register the accepted op onto the core inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_v    <= 1'b0;
      core_mode <= 1'b0;
      core_x    <= '0;
      issue_id  <= '0;
    end else begin
      core_v <= grant;
      if (grant) begin
        core_mode <= grant_sp;
        core_x    <= grant_sp ? sp_x : exp_x;
        issue_id  <= grant_sp ? sp_id : exp_id;
      end
    end
  end

  // Tag pipeline fed from the issue stage; its last entry lines up with the
  // core result cycle.
  // NOTE: this shift array is reset because its valid bits must be clear after reset;
  // stale core results are then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT_CORE; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{v: core_v, mode: core_mode, id: issue_id};
      for (int i = 1; i < LAT_CORE; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign head = tag_q[LAT_CORE-1];

  // Any op still travelling through the tag pipeline.
  always_comb begin
    any_tag_v = 1'b0;
    for (int i = 0; i < LAT_CORE; i++) any_tag_v = any_tag_v | tag_q[i].v;
  end

  assign idle = ~any_tag_v & ~core_v & ~grant;

  // Registered responses: route the core result to the owner of the head tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_rsp_v   <= 1'b0;
      sp_y       <= '0;
      sp_rsp_id  <= '0;
      exp_rsp_v  <= 1'b0;
      exp_y      <= '0;
      exp_rsp_id <= '0;
    end else begin
      sp_rsp_v  <= head.v & head.mode & core_v_s;
      exp_rsp_v <= head.v & ~head.mode & core_v_e;
      if (head.v && head.mode && core_v_s) begin
        sp_y      <= core_y_s;
        sp_rsp_id <= head.id;
      end
      if (head.v && !head.mode && core_v_e) begin
        exp_y      <= core_y_e;
        exp_rsp_id <= head.id;
      end
    end
  end

`ifdef EXP_SP_ARB_CHK_EN
  logic chk_bad;

  // Compare core valids against what the head tag expects this cycle.
  always_comb begin
    chk_bad = core_v_s & core_v_e;
    if (head.v) begin
      if (head.mode) chk_bad = chk_bad | ~core_v_s | core_v_e;
      else           chk_bad = chk_bad | ~core_v_e | core_v_s;
    end else begin
      chk_bad = chk_bad | core_v_s | core_v_e;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (chk_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_exp_sp_arbiter.sv
// Directed testbench for exp_sp_arbiter with a fixed-latency core stub.
// Stub results: softplus y = x + 1, exp y = ~x.
module tb_exp_sp_arbiter;
  localparam int DW  = 16;
  localparam int IDW = 4;
  localparam int LAT = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           sp_req_v, exp_req_v;
  logic           sp_req_rdy, exp_req_rdy;
  logic [DW-1:0]  sp_x, exp_x;
  logic [IDW-1:0] sp_id, exp_id;
  logic           core_v, core_mode;
  logic [DW-1:0]  core_x;
  logic [DW-1:0]  core_y_s, core_y_e;
  logic           core_v_s, core_v_e;
  logic           sp_rsp_v, exp_rsp_v;
  logic [DW-1:0]  sp_y, exp_y;
  logic [IDW-1:0] sp_rsp_id, exp_rsp_id;
  logic           idle, err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic swap = 1'b0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  y;
    int             cyc;
  } rsp_t;
  rsp_t sp_q[$];
  rsp_t exp_q[$];

  exp_sp_arbiter #(.DW(DW), .IDW(IDW), .LAT_CORE(LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .sp_req_v(sp_req_v), .sp_req_rdy(sp_req_rdy), .sp_x(sp_x), .sp_id(sp_id),
    .exp_req_v(exp_req_v), .exp_req_rdy(exp_req_rdy), .exp_x(exp_x), .exp_id(exp_id),
    .core_v(core_v), .core_mode(core_mode), .core_x(core_x),
    .core_y_s(core_y_s), .core_v_s(core_v_s), .core_y_e(core_y_e), .core_v_e(core_v_e),
    .sp_rsp_v(sp_rsp_v), .sp_y(sp_y), .sp_rsp_id(sp_rsp_id),
    .exp_rsp_v(exp_rsp_v), .exp_y(exp_y), .exp_rsp_id(exp_rsp_id),
    .idle(idle), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: fixed LAT-cycle delay, not reset (emits stale results after rst).
  logic          st_v [LAT];
  logic          st_m [LAT];
  logic [DW-1:0] st_x [LAT];
  initial for (int i = 0; i < LAT; i++) begin st_v[i] = 1'b0; st_m[i] = 1'b0; st_x[i] = '0; end
  always @(posedge clk) begin
    st_v[0] <= core_v; st_m[0] <= core_mode; st_x[0] <= core_x;
    for (int i = 1; i < LAT; i++) begin
      st_v[i] <= st_v[i-1]; st_m[i] <= st_m[i-1]; st_x[i] <= st_x[i-1];
    end
  end
  assign core_v_s = st_v[LAT-1] & (st_m[LAT-1] ^ swap);
  assign core_v_e = st_v[LAT-1] & ~(st_m[LAT-1] ^ swap);
  assign core_y_s = st_x[LAT-1] + 16'd1;
  assign core_y_e = ~st_x[LAT-1];

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sp_rsp_v)  sp_q.push_back('{id: sp_rsp_id, y: sp_y, cyc: cyc});
    if (exp_rsp_v) exp_q.push_back('{id: exp_rsp_id, y: exp_y, cyc: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sp_req_v = 1'b0; exp_req_v = 1'b0;
    sp_x = '0; exp_x = '0; sp_id = '0; exp_id = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int a;
  int sp_n, exp_n;

  initial begin
    en = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_core_v", core_v, 0);
    check("rst_core_mode", core_mode, 0);
    check("rst_core_x", core_x, 0);
    check("rst_idle", idle, 1);
    check("rst_err", err, 0);
    check("rst_sp_rsp", {sp_rsp_v, sp_y, sp_rsp_id}, 0);
    check("rst_exp_rsp", {exp_rsp_v, exp_y, exp_rsp_id}, 0);

    // Test 1: single SP op, latency LAT+2
    sp_q.delete(); exp_q.delete();
    sp_req_v = 1'b1; sp_x = 16'h3C00; sp_id = 4'd5;
    #1;
    check("t1_sp_rdy", sp_req_rdy, 1);
    check("t1_exp_rdy", exp_req_rdy, 0);
    check("t1_idle_busy", idle, 0);
    a = cyc;
    step();
    idle_inputs();
    check("t1_core_v", core_v, 1);
    check("t1_core_mode", core_mode, 1);
    check("t1_core_x", core_x, 16'h3C00);
    repeat (LAT + 6) step();
    check("t1_sp_cnt", sp_q.size(), 1);
    check("t1_exp_cnt", exp_q.size(), 0);
    if (sp_q.size() == 1) begin
      check("t1_lat", sp_q[0].cyc - a, LAT + 2);
      check("t1_id", sp_q[0].id, 5);
      check("t1_y", sp_q[0].y, 16'h3C01);
    end
    check("t1_idle_end", idle, 1);

    // Test 2: contention, alternating grants starting with SP
    do_reset();
    sp_q.delete(); exp_q.delete();
    sp_n = 0; exp_n = 8;
    for (int k = 0; k < 4; k++) begin
      sp_req_v = 1'b1; sp_id = sp_n[IDW-1:0]; sp_x = 16'(sp_n << 8);
      exp_req_v = 1'b1; exp_id = exp_n[IDW-1:0]; exp_x = 16'(16'h1000 + exp_n);
      #1;
      check($sformatf("t2_sp_rdy%0d", k), sp_req_rdy, (k % 2 == 0));
      check($sformatf("t2_exp_rdy%0d", k), exp_req_rdy, (k % 2 == 1));
      if (sp_req_rdy) sp_n++;
      if (exp_req_rdy) exp_n++;
      step();
    end
    idle_inputs();
    repeat (LAT + 6) step();
    check("t2_sp_cnt", sp_q.size(), 2);
    check("t2_exp_cnt", exp_q.size(), 2);
    if (sp_q.size() == 2 && exp_q.size() == 2) begin
      check("t2_sp0_id", sp_q[0].id, 0);
      check("t2_sp0_y", sp_q[0].y, 16'h0001);
      check("t2_sp1_id", sp_q[1].id, 1);
      check("t2_sp1_y", sp_q[1].y, 16'h0101);
      check("t2_exp0_id", exp_q[0].id, 8);
      check("t2_exp0_y", exp_q[0].y, 16'hEFF7);
      check("t2_exp1_id", exp_q[1].id, 9);
      check("t2_exp1_y", exp_q[1].y, 16'hEFF6);
      check("t2_order0", exp_q[0].cyc - sp_q[0].cyc, 1);
      check("t2_order1", sp_q[1].cyc - exp_q[0].cyc, 1);
      check("t2_order2", exp_q[1].cyc - sp_q[1].cyc, 1);
    end

    // Test 3: 20 back-to-back EXP ops
    sp_q.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      exp_req_v = 1'b1; exp_id = 4'(i % 16); exp_x = 16'(16'h2000 + i);
      #1;
      check($sformatf("t3_rdy%0d", i), exp_req_rdy, 1);
      if (i > 0) check($sformatf("t3_core_v%0d", i), core_v, 1);
      step();
    end
    idle_inputs();
    repeat (LAT + 6) step();
    check("t3_cnt", exp_q.size(), 20);
    check("t3_sp_cnt", sp_q.size(), 0);
    if (exp_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("t3_id%0d", i), exp_q[i].id, i % 16);
        check($sformatf("t3_y%0d", i), exp_q[i].y, 16'(~(16'h2000 + i)));
        check($sformatf("t3_cyc%0d", i), exp_q[i].cyc - exp_q[0].cyc, i);
      end
    end

    // Test 4: en low blocks grants; raising en grants SP first
    sp_q.delete(); exp_q.delete();
    en = 1'b0;
    sp_req_v = 1'b1; sp_id = 4'd3; sp_x = 16'h0042;
    exp_req_v = 1'b1; exp_id = 4'd7; exp_x = 16'h0099;
    #1;
    check("t4_sp_rdy_off", sp_req_rdy, 0);
    check("t4_exp_rdy_off", exp_req_rdy, 0);
    repeat (LAT + 4) step();
    check("t4_core_v_off", core_v, 0);
    check("t4_idle_off", idle, 1);
    en = 1'b1;
    #1;
    check("t4_sp_rdy_on", sp_req_rdy, 1);
    check("t4_exp_rdy_on", exp_req_rdy, 0);
    check("t4_idle_on", idle, 0);
    step();
    idle_inputs();
    repeat (LAT + 6) step();
    check("t4_sp_cnt", sp_q.size(), 1);
    check("t4_exp_cnt", exp_q.size(), 0);
    if (sp_q.size() == 1) check("t4_sp_id", sp_q[0].id, 3);

    // Test 5: reset with ops in flight drops them
    sp_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      sp_req_v = 1'b1; sp_id = 4'(i + 1); sp_x = 16'(i);
      step();
    end
    idle_inputs();
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("t5_idle_rst", idle, 1);
    check("t5_core_v_rst", core_v, 0);
    check("t5_err_rst", err, 0);
    step();
    rst = 1'b0;
    repeat (LAT + 6) step();
    check("t5_sp_cnt", sp_q.size(), 0);
    check("t5_exp_cnt", exp_q.size(), 0);
    check("t5_idle_end", idle, 1);

    // Test 6: core answers an SP op with the EXP valid
    do_reset();
    sp_q.delete(); exp_q.delete();
    check("t6_err_pre", err, 0);
    swap = 1'b1;
    sp_req_v = 1'b1; sp_id = 4'd2; sp_x = 16'h0123;
    step();
    idle_inputs();
    repeat (LAT + 4) step();
`ifdef EXP_SP_ARB_CHK_EN
    check("t6_err_set", err, 1);
    repeat (5) step();
    check("t6_err_sticky", err, 1);
`else
    check("t6_err_tied", err, 0);
`endif
    check("t6_sp_cnt", sp_q.size(), 0);
    check("t6_exp_cnt", exp_q.size(), 0);
    swap = 1'b0;
    do_reset();
    check("t6_err_clr", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
